// File: rtl/delay_match_counter.sv
// delay_match_counter: checks b exactly DELAY sampled cycles after each a, counting matches and misses
module delay_match_counter #(
  parameter int DELAY = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             match,
  output logic             miss,
  output logic             busy,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             sat
);
  logic [DELAY-1:0] sr, sr_d;
  logic             hit, lose;
  logic [CNT_W-1:0] mc_d, xc_d;
  always_comb begin
    sr_d = en ? DELAY'({sr, a}) : sr;
    hit  = en & sr[DELAY-1] & b;
    lose = en & sr[DELAY-1] & ~b;
    mc_d = (hit && match_count != '1) ? match_count + CNT_W'(1) : match_count;
    xc_d = (lose && miss_count != '1) ? miss_count + CNT_W'(1) : miss_count;
  end
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      sr          <= '0;
      busy        <= 1'b0;
      match       <= 1'b0;
      miss        <= 1'b0;
      match_count <= '0;
      miss_count  <= '0;
      sat         <= 1'b0;
    end else begin
      sr          <= sr_d;
      busy        <= |sr_d;
      match       <= hit;
      miss        <= lose;
      match_count <= mc_d;
      miss_count  <= xc_d;
      sat         <= sat | (&mc_d) | (&xc_d);
    end
endmodule

// File: tb/tb_delay_match_counter.sv
// tb_delay_match_counter: scoreboard bench for delay_match_counter at DELAY=3, CNT_W=4
module tb_delay_match_counter;
  localparam int DELAY = 3;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr = 1'b0, a = 1'b0, b = 1'b0;
  logic match, miss, busy, sat;
  logic [CNT_W-1:0] match_count, miss_count;

  delay_match_counter #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .match(match), .miss(miss), .busy(busy),
    .match_count(match_count), .miss_count(miss_count), .sat(sat)
  );

  always #5 clk = ~clk;

  int vecs = 0, fails = 0;
  int pend[$];
  int m_mc = 0, m_xc = 0;
  logic m_sat = 1'b0;
  logic [11:0] sb[$];
  logic [11:0] e;

  // drive one edge, advance the reference model, queue its expected outputs
  task automatic tick(input logic ia, input logic ib, input logic ien,
                      input logic iclr, input logic irst);
    int nq[$];
    logic em, ex;
    @(negedge clk);
    a = ia; b = ib; en = ien; clr = iclr; rst_n = irst;
    em = 1'b0; ex = 1'b0;
    if (!irst || iclr) begin
      pend.delete(); m_mc = 0; m_xc = 0; m_sat = 1'b0;
    end else if (ien) begin
      foreach (pend[i])
        if (pend[i] == 1) begin
          em = ib; ex = ~ib;
        end else nq.push_back(pend[i] - 1);
      if (ia) nq.push_back(DELAY);
      pend = nq;
      if (em && m_mc != MAXC) m_mc++;
      if (ex && m_xc != MAXC) m_xc++;
      m_sat = m_sat | (m_mc == MAXC) | (m_xc == MAXC);
    end
    sb.push_back({em, ex, pend.size() != 0, m_sat, 4'(m_mc), 4'(m_xc)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e || e !== 12'h0) begin
        fails++;
        $display("FAIL reset: got %h expected %h", {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
  endtask

  task automatic test_single;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 16; k++) begin
      tick(k == 10, k == 13, 1'b1, 1'b0, 1'b1);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e || match !== (k == 13)) begin
        fails++;
        $display("FAIL single edge %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
    vecs++;
    if (match_count !== 4'd1 || miss_count !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single totals: got mc=%0d xc=%0d busy=%b expected 1 0 0", match_count, miss_count, busy);
    end
  endtask

  task automatic test_overlap;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 17; k++) begin
      tick(k >= 10 && k <= 12, k == 13 || k == 15, 1'b1, 1'b0, 1'b1);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e ||
          match !== (k == 13 || k == 15) || miss !== (k == 14)) begin
        fails++;
        $display("FAIL overlap edge %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
    vecs++;
    if (match_count !== 4'd2 || miss_count !== 4'd1) begin
      fails++;
      $display("FAIL overlap totals: got mc=%0d xc=%0d expected 2 1", match_count, miss_count);
    end
  endtask

  task automatic test_enable;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 17; k++) begin
      tick(k == 10 || k == 11, k == 15 || k == 12, !(k == 11 || k == 12), 1'b0, 1'b1);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e ||
          match !== (k == 15) || miss !== 1'b0) begin
        fails++;
        $display("FAIL enable edge %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
  endtask

  task automatic test_saturate;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 22; k++) begin
      tick(k <= 17, 1'b1, 1'b1, 1'b0, 1'b1);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e || sat !== (k >= 18)) begin
        fails++;
        $display("FAIL saturate edge %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
    vecs++;
    if (match_count !== 4'd15 || miss_count !== 4'd0 || sat !== 1'b1) begin
      fails++;
      $display("FAIL saturate totals: got mc=%0d xc=%0d sat=%b expected 15 0 1", match_count, miss_count, sat);
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k <= 18; k++) begin
      tick(k == 10, 1'b1, 1'b1, 1'b0, k != 11);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e ||
          (k >= 11 && {match, miss, match_count, miss_count} !== 10'h0)) begin
        fails++;
        $display("FAIL reset_mid edge %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
  endtask

  task automatic test_clr;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 1; k <= 17; k++) begin
      tick(k == 10 || k == 13, k == 13, 1'b1, k == 13, 1'b1);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e || match !== 1'b0 || miss !== 1'b0) begin
        fails++;
        $display("FAIL clr edge %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
    vecs++;
    if (match_count !== 4'd0 || miss_count !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clr totals: got mc=%0d xc=%0d busy=%b expected 0 0 0", match_count, miss_count, busy);
    end
  endtask

  task automatic test_back_to_back;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 150) != 0);
      e = sb.pop_front();
      vecs++;
      if ({match, miss, busy, sat, match_count, miss_count} !== e || (match & miss) !== 1'b0) begin
        fails++;
        $display("FAIL random cycle %0d: got %h expected %h", k, {match, miss, busy, sat, match_count, miss_count}, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_overlap;
    test_enable;
    test_saturate;
    test_reset_mid;
    test_clr;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
